// File: rtl/cc_frame_receive.sv
// cc_frame_receive: 8N1 deserializer that packs bytes into 32-bit frame-RAM writes and flags frame completion or corruption
module cc_frame_receive #(
  parameter int CLK_DIV     = 16,
  parameter int SOUND_WORDS = 500,
  parameter int PARAM_WORDS = 12,
  parameter int GAP_BITS    = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_param,
  output logic        frame_done,
  output logic        frame_err,
  output logic [3:0]  frame_cnt,
  output logic        busy
);
  localparam int TW      = SOUND_WORDS + PARAM_WORDS;
  localparam int GAP_LIM = GAP_BITS * CLK_DIV;
  localparam int CW      = $clog2(CLK_DIV);
  localparam int GW      = $clog2(GAP_LIM + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, next;
  logic rx_m, rxs;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [31:0] word;
  logic [1:0] lane;
  logic [9:0] words;
  logic bad, got;
  logic [GW-1:0] gap;
  logic half_tick, bit_tick, byte_ok, stop_bad, boundary, good;
  // two-flop synchronizer; idle-high line so reset value is 1
  always_ff @(posedge clock)
    if (reset) {rx_m, rxs} <= 2'b11;
    else {rx_m, rxs} <= {rx, rx_m};
  // bit-level FSM state register
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= next;
  // sample strobes, frame boundary detection and next-state decode
  always_comb begin
    half_tick = state == START && cnt == CW'(CLK_DIV / 2 - 1);
    bit_tick  = (state == DATA || state == STOP) && cnt == CW'(CLK_DIV - 1);
    byte_ok   = state == STOP && bit_tick && rxs;
    stop_bad  = state == STOP && bit_tick && !rxs;
    boundary  = state == IDLE && rxs && gap == GW'(GAP_LIM - 1);
    good      = words == 10'(TW) && lane == 2'd0 && !bad;
    next      = state;
    case (state)
      IDLE:    next = rxs ? IDLE : START;
      START:   if (half_tick) next = rxs ? IDLE : DATA;
      DATA:    if (bit_tick && bit_idx == 3'd7) next = STOP;
      default: if (bit_tick) next = IDLE;
    endcase
  end
  // bit timing, data shift register and idle-gap counter
  always_ff @(posedge clock)
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      gap     <= '0;
    end else begin
      cnt     <= (state == IDLE || next != state || bit_tick) ? '0 : cnt + CW'(1);
      bit_idx <= state == DATA ? bit_idx + 3'(bit_tick) : '0;
      shreg   <= (state == DATA && bit_tick) ? {rxs, shreg[7:1]} : shreg;
      gap     <= state != IDLE ? '0 : (rxs && gap != GW'(GAP_LIM)) ? gap + GW'(1) : gap;
    end
  // word assembly, RAM write strobe and frame-level bookkeeping
  always_ff @(posedge clock)
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_param   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      word       <= '0;
      lane       <= '0;
      words      <= '0;
      bad        <= 1'b0;
      got        <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE && !rxs) busy <= 1'b1;
      if (stop_bad) bad <= 1'b1;
      if (byte_ok) begin
        got <= 1'b1;
        if (words == 10'(TW)) bad <= 1'b1;
        else begin
          word <= {shreg, word[31:8]};
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            wr_en    <= 1'b1;
            wr_addr  <= words;
            wr_data  <= {shreg, word[31:8]};
            wr_param <= words >= 10'(SOUND_WORDS);
            words    <= words + 10'd1;
          end
        end
      end
      if (boundary) begin
        frame_done <= good;
        frame_err  <= !good && (got || bad);
        frame_cnt  <= frame_cnt + 4'(good);
        words      <= '0;
        lane       <= '0;
        bad        <= 1'b0;
        got        <= 1'b0;
        busy       <= 1'b0;
      end
    end
endmodule

// File: tb/tb_cc_frame_receive.sv
// tb_cc_frame_receive: randomized frame stimulus checked against a byte-level frame model
module tb_cc_frame_receive;
  localparam int CD = 8, SW = 4, PW = 2, GB = 20, TW = SW + PW;
  logic clock = 0, reset = 1, rx = 1;
  logic wr_en, wr_param, frame_done, frame_err, busy;
  logic [9:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0] frame_cnt;
  typedef struct packed {logic [9:0] a; logic [31:0] d; logic p;} wr_t;
  typedef struct packed {logic done; logic [3:0] cnt;} ev_t;
  wr_t wq[$];
  ev_t eq[$];
  wr_t we;
  ev_t ee;
  int checks = 0, fails = 0;
  logic [3:0] cnt_m = 0;
  logic [7:0] fb[$];
  bit fs[$];

  cc_frame_receive #(.CLK_DIV(CD), .SOUND_WORDS(SW), .PARAM_WORDS(PW), .GAP_BITS(GB)) dut (
    .clock(clock), .reset(reset), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_param(wr_param), .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  // expected writes and frame outcome derived from the byte list alone
  function automatic void model(bit ev);
    logic [7:0] v[$];
    bit bad = 0;
    foreach (fb[i]) if (fs[i]) v.push_back(fb[i]); else bad = 1;
    if (v.size() > 4 * TW) bad = 1;
    for (int w = 0; w < TW && 4 * w + 3 < v.size(); w++)
      wq.push_back({10'(w), v[4*w+3], v[4*w+2], v[4*w+1], v[4*w], 1'(w >= SW)});
    if (!ev) return;
    if (!bad && v.size() == 4 * TW) begin
      cnt_m++;
      eq.push_back({1'b1, cnt_m});
    end else if (bad || v.size() > 0) eq.push_back({1'b0, cnt_m});
  endfunction

  task automatic idle(int n);
    rx = 1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(logic [7:0] b, bit ok);
    rx = 0;
    repeat (CD) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CD) @(negedge clock);
    end
    rx = ok;
    repeat (CD) @(negedge clock);
    rx = 1;
    if (!ok) repeat (2 * CD) @(negedge clock);
  endtask

  task automatic make_frame(int n, bit seq, int bad_idx);
    fb.delete();
    fs.delete();
    for (int i = 0; i < n; i++) begin
      fb.push_back(seq ? (i % 4 == 3 ? 8'hA5 : i % 4 == 0 ? 8'(i / 4) : 8'h00) : 8'($urandom));
      fs.push_back(i != bad_idx);
    end
  endtask

  task automatic send_frame(string n);
    model(1);
    foreach (fb[i]) begin
      send_byte(fb[i], fs[i]);
      idle($urandom_range(0, 3));
    end
    idle((GB + 3) * CD);
    chk({n, " writes drained"}, 64'(wq.size()), 0);
    chk({n, " events drained"}, 64'(eq.size()), 0);
  endtask

  task automatic do_reset();
    reset = 1;
    rx = 1;
    repeat (4) begin
      @(negedge clock);
      chk("outputs in reset", {wr_en, wr_addr, wr_data, wr_param, frame_done, frame_err, frame_cnt, busy}, 0);
    end
    reset = 0;
    cnt_m = 0;
    wq.delete();
    eq.delete();
  endtask

  always @(negedge clock)
    if (!reset) begin
      chk("done/err exclusive", 64'(frame_done & frame_err), 0);
      if (wr_en) begin
        if (wq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected write: addr %0d data 0x%0h, expected none", wr_addr, wr_data);
        end else begin
          we = wq.pop_front();
          chk("write busy/param/addr/data", {busy, wr_param, wr_addr, wr_data}, {1'b1, we.p, we.a, we.d});
        end
      end
      if (frame_done || frame_err) begin
        if (eq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected frame pulse: done %0b err %0b, expected none", frame_done, frame_err);
        end else begin
          ee = eq.pop_front();
          chk("frame busy/done/err/cnt", {busy, frame_done, frame_err, frame_cnt}, {1'b0, ee.done, ~ee.done, ee.cnt});
        end
      end
    end

  initial begin
    do_reset();
    idle(10);
    make_frame(4 * TW, 1, -1);
    send_frame("good");
    chk("cnt after good", frame_cnt, 1);
    chk("last write held", {wr_param, wr_addr, wr_data}, {1'b1, 10'd5, 32'hA5000005});
    make_frame(4 * TW, 0, 5);
    send_frame("stop err");
    chk("cnt after stop err", frame_cnt, 1);
    make_frame(4 * TW - 4, 0, -1);
    send_frame("short");
    make_frame(4 * TW + 4, 0, -1);
    send_frame("long");
    make_frame(4 * TW - 2, 0, -1);
    send_frame("partial");
    chk("cnt after bad frames", frame_cnt, 1);
    rx = 0;
    repeat (3) @(negedge clock);
    idle((GB + 3) * CD);
    chk("busy after glitch", busy, 0);
    make_frame(4 * TW, 0, -1);
    send_frame("after glitch");
    chk("cnt after glitch frame", frame_cnt, 2);
    make_frame(12, 0, -1);
    model(0);
    foreach (fb[i]) send_byte(fb[i], fs[i]);
    chk("pre-reset writes", 64'(wq.size()), 0);
    rx = 0;
    repeat (5 * CD) @(negedge clock);
    do_reset();
    idle(10);
    make_frame(4 * TW, 1, -1);
    send_frame("post reset");
    chk("cnt after reset frame", frame_cnt, 1);
    do_reset();
    for (int f = 1; f <= 17; f++) begin
      make_frame(4 * TW, 0, -1);
      send_frame("wrap");
      if (f == 16) chk("wrap cnt at 16", frame_cnt, 0);
    end
    chk("wrap cnt at 17", frame_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cc_frame_receive.md
# cc_frame_receive

Serial receiver for the CC audio/flight link. It deserializes the 8N1 byte stream produced by the CC transmit path and reassembles it into 32-bit words. Each frame is 500 sound words followed by 12 flight-parameter words. Words are written into an external dual-port frame RAM, and the block flags frame completion or frame corruption. It sits on the ground/test side of the CC link, or in loopback on the same FPGA, and feeds playback and parameter decoders.

## Interface
- CLK_DIV, 16: clocks per serial bit; must be even and ≥ 8.
- SOUND_WORDS, 500: sound words per frame.
- PARAM_WORDS, 12: flight-parameter words per frame.
- GAP_BITS, 20: idle bit-times that delimit frames.
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- rx  in  1  serial line; asynchronous to clock; idle high.
- wr_en  out  1  one-cycle word write strobe.
- wr_addr  out  10  word address within frame, 0..SOUND_WORDS+PARAM_WORDS-1.
- wr_data  out  32  assembled word; first received byte is bits [7:0].
- wr_param  out  1  high with wr_en when wr_addr ≥ SOUND_WORDS.
- frame_done  out  1  one-cycle pulse: complete, error-free frame received.
- frame_err  out  1  one-cycle pulse: frame ended short, long, or with a stop-bit error.
- frame_cnt  out  4  count of good frames; wraps modulo 16.
- busy  out  1  high from the first start bit of a frame until the frame boundary.

## Operation
- rx passes through a 2-FF synchronizer. All logic uses the synchronized value rxs.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on rxs = 0.
  - In START, at CLK_DIV/2 clocks: if rxs = 0, go to DATA. Otherwise it is a glitch; return to IDLE with no error.
  - DATA samples 8 bits every CLK_DIV clocks, LSB first, then goes to STOP.
  - STOP samples once after CLK_DIV clocks. rxs = 1 gives a valid byte. rxs = 0 sets the sticky bad flag and discards the byte. In both cases the FSM returns to IDLE.
- Byte assembly:
  - Valid bytes shift into a 32-bit word, little-endian.
  - A 2-bit lane counter tracks position. On the 4th byte, wr_en pulses with wr_addr = word counter.
  - The word counter then increments.
  - When the word counter reaches SOUND_WORDS+PARAM_WORDS, further bytes are not written and set the bad flag (overlong frame).
- Gap detector:
  - Counts clocks while the FSM is in IDLE and rxs = 1. Any non-IDLE state clears the count.
  - When the count reaches GAP_BITS*CLK_DIV, a frame boundary occurs, evaluated in that cycle:
    - Good frame: word counter = SOUND_WORDS+PARAM_WORDS, lane = 0, and bad flag = 0. Pulse frame_done; frame_cnt increments.
    - Otherwise, if any byte was received or bad is set: pulse frame_err.
    - If nothing was received: no pulse.
  - At the boundary, clear the word counter, lane counter, bad flag and busy. The gap counter saturates and no further boundary fires until new activity.
- A partial word, i.e. a lane count other than 0 at the boundary, is never written.

## Timing
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, wr_param = 0, frame_done = 0, frame_err = 0, frame_cnt = 0, busy = 0. The FSM enters IDLE and all counters clear.
- Assertion of reset mid-byte or mid-frame discards all partial state. No pulse is produced.
- Synchronizer latency is 2 clocks from rx to rxs.
- The start bit is confirmed CLK_DIV/2 clocks after the falling edge of rxs. Each data sample is taken CLK_DIV clocks after the previous one.
- wr_en and wr_data/wr_addr/wr_param are registered. They are valid in the cycle after the stop-bit sample of the 4th byte and are held until the next write.
- frame_done and frame_err are valid 1 clock after the gap count is reached. They are mutually exclusive.
- frame_cnt updates in the same cycle as frame_done.
- Back-to-back bytes with zero idle between the stop bit and the next start bit must be received. A stop bit followed by an immediate falling edge goes straight to START on the next cycle.
- A start edge that arrives in the same cycle the gap count is reached is handled in this order: the boundary is processed first, then the edge begins the new frame.

## Test plan
- Good frame: send 2048 bytes (word n = 0xA5000000|n), then 20 idle bits. Expect 512 writes with addr 0..511 and data matching. wr_param is high for addr 500..511. Expect one frame_done and frame_cnt = 1.
- Stop-bit error: corrupt the stop bit of byte 100 and send the rest normally. Expect no write of that byte, then frame_err with no frame_done, and frame_cnt unchanged.
- Short/long frames:
  - 2044 bytes: 511 writes, then frame_err.
  - 2052 bytes: 512 writes only, then frame_err.
  - 2046 bytes: partial last word not written, then frame_err.
- Glitch: a 3-clock low pulse on rx while idle. Expect no write, no error and no pulse; the next good frame still gives frame_done.
- Wrap: 17 consecutive good frames. Expect frame_cnt to go 1..15, 0, 1. wr_addr restarts at 0 each frame.
- Reset mid-frame: assert reset after 1000 bytes, then send a full good frame. All outputs read zero during reset. The new frame gives 512 writes from addr 0, then frame_done and frame_cnt = 1.
